// File: rtl/trans_mem_responder.sv
// AXI4 slave backed by a single-port 512-bit RAM of 2^DEPTH_LOG2 entries.
// Independent read and write FSMs; a write beat wins the RAM port over a read issue.
module trans_mem_responder #(
    parameter int unsigned DEPTH_LOG2   = 10,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,

    input  logic [31:0]  trans_axi_awaddr,
    input  logic [7:0]   trans_axi_awlen,
    input  logic [1:0]   trans_axi_awburst,
    input  logic [2:0]   trans_axi_awsize,
    input  logic         trans_axi_awvalid,
    output logic         trans_axi_awready,

    input  logic [511:0] trans_axi_wdata,
    input  logic [63:0]  trans_axi_wstrb,
    input  logic         trans_axi_wlast,
    input  logic         trans_axi_wvalid,
    output logic         trans_axi_wready,

    output logic [1:0]   trans_axi_bresp,
    output logic         trans_axi_bvalid,
    input  logic         trans_axi_bready,

    input  logic [31:0]  trans_axi_araddr,
    input  logic [7:0]   trans_axi_arlen,
    input  logic [1:0]   trans_axi_arburst,
    input  logic [2:0]   trans_axi_arsize,
    input  logic         trans_axi_arvalid,
    output logic         trans_axi_arready,

    output logic [511:0] trans_axi_rdata,
    output logic [1:0]   trans_axi_rresp,
    output logic         trans_axi_rlast,
    output logic         trans_axi_rvalid,
    input  logic         trans_axi_rready
);

    localparam int unsigned DEPTH       = 2 ** DEPTH_LOG2;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef logic [DEPTH_LOG2-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_t;

    logic [511:0] mem [DEPTH];

    logic [31:0] aw_off;
    logic [31:0] ar_off;

    w_state_t    w_state;
    w_state_t    w_next;
    idx_t        w_idx;
    logic [7:0]  w_len;
    logic [1:0]  w_burst;
    logic [7:0]  w_cnt;
    logic        w_err;
    logic [1:0]  bresp_q;
    logic        w_beat;

    r_state_t    r_state;
    r_state_t    r_next;
    idx_t        r_idx;
    logic [7:0]  r_len;
    logic [1:0]  r_burst;
    logic [7:0]  r_cnt;
    logic        r_last;
    logic        rd_issue;
    logic [511:0] rdata_q;

    // Size fields are accepted but always treated as full 64-byte beats.
    logic unused_ok;
    assign unused_ok = ^{trans_axi_awsize, trans_axi_arsize, aw_off, ar_off};

    assign aw_off          = trans_axi_awaddr - BASE_ADDRESS;
    assign ar_off          = trans_axi_araddr - BASE_ADDRESS;
    assign trans_axi_rdata = rdata_q;
    assign trans_axi_rresp = RESP_OKAY;
    assign r_last          = (r_cnt == r_len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next            = w_state;
        trans_axi_awready = 1'b0;
        trans_axi_wready  = 1'b0;
        trans_axi_bvalid  = 1'b0;
        trans_axi_bresp   = RESP_OKAY;
        w_beat            = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                trans_axi_awready = 1'b1;
                if (trans_axi_awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                trans_axi_wready = 1'b1;
                if (trans_axi_wvalid) begin
                    w_beat = 1'b1;
                    if (w_cnt == w_len) w_next = W_RESP;
                end
            end
            W_RESP: begin
                trans_axi_bvalid = 1'b1;
                trans_axi_bresp  = bresp_q;
                if (trans_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next            = r_state;
        trans_axi_arready = 1'b0;
        trans_axi_rvalid  = 1'b0;
        trans_axi_rlast   = 1'b0;
        rd_issue          = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                trans_axi_arready = 1'b1;
                if (trans_axi_arvalid) r_next = R_READ;
            end
            R_READ: begin
                // A write beat owns the RAM port this cycle; retry next cycle.
                if (!w_beat) begin
                    rd_issue = 1'b1;
                    r_next   = R_DATA;
                end
            end
            R_DATA: begin
                trans_axi_rvalid = 1'b1;
                trans_axi_rlast  = r_last;
                if (trans_axi_rready) r_next = r_last ? R_IDLE : R_READ;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_idx   <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else begin
            if (w_state == W_IDLE && trans_axi_awvalid) begin
                w_idx   <= aw_off[DEPTH_LOG2+5:6];
                w_len   <= trans_axi_awlen;
                w_burst <= trans_axi_awburst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end
            if (w_beat) begin
                w_cnt <= w_cnt + 8'd1;
                if (trans_axi_wlast && (w_cnt != w_len)) w_err <= 1'b1;
                if (w_burst != BURST_FIXED) w_idx <= w_idx + idx_t'(1);
                if (w_cnt == w_len)
                    bresp_q <= (trans_axi_wlast && !w_err) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx   <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            if (r_state == R_IDLE && trans_axi_arvalid) begin
                r_idx   <= ar_off[DEPTH_LOG2+5:6];
                r_len   <= trans_axi_arlen;
                r_burst <= trans_axi_arburst;
                r_cnt   <= '0;
            end
            if (r_state == R_DATA && trans_axi_rready && !r_last) begin
                r_cnt <= r_cnt + 8'd1;
                if (r_burst != BURST_FIXED) r_idx <= r_idx + idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat) begin
            for (int unsigned k = 0; k < 64; k++) begin
                if (trans_axi_wstrb[k]) mem[w_idx][8*k +: 8] <= trans_axi_wdata[8*k +: 8];
            end
        end
        if (rd_issue) rdata_q <= mem[r_idx];
    end

endmodule

// File: tb/tb_trans_mem_responder.sv
// Randomized self-checking bench for trans_mem_responder against an entry-array model.
module tb_trans_mem_responder;

    localparam int unsigned DL    = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic         clk;
    logic         reset;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [1:0]   awburst;
    logic [2:0]   awsize;
    logic         awvalid;
    logic         awready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [1:0]   arburst;
    logic [2:0]   arsize;
    logic         arvalid;
    logic         arready;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    trans_mem_responder #(
        .DEPTH_LOG2   (DL),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .trans_axi_awaddr  (awaddr),
        .trans_axi_awlen   (awlen),
        .trans_axi_awburst (awburst),
        .trans_axi_awsize  (awsize),
        .trans_axi_awvalid (awvalid),
        .trans_axi_awready (awready),
        .trans_axi_wdata   (wdata),
        .trans_axi_wstrb   (wstrb),
        .trans_axi_wlast   (wlast),
        .trans_axi_wvalid  (wvalid),
        .trans_axi_wready  (wready),
        .trans_axi_bresp   (bresp),
        .trans_axi_bvalid  (bvalid),
        .trans_axi_bready  (bready),
        .trans_axi_araddr  (araddr),
        .trans_axi_arlen   (arlen),
        .trans_axi_arburst (arburst),
        .trans_axi_arsize  (arsize),
        .trans_axi_arvalid (arvalid),
        .trans_axi_arready (arready),
        .trans_axi_rdata   (rdata),
        .trans_axi_rresp   (rresp),
        .trans_axi_rlast   (rlast),
        .trans_axi_rvalid  (rvalid),
        .trans_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic         last;
    } rbeat_t;

    logic [511:0] mm [DEPTH];
    rbeat_t       exp_rq [$];
    logic [1:0]   exp_bq [$];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int unsigned midx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off / 64) % DEPTH;
    endfunction

    function automatic int unsigned nidx(input int unsigned i, input logic [1:0] burst);
        return (burst == 2'b00) ? i : (i + 1) % DEPTH;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Every cycle: outputs during reset, and read/response beats against the expectation queues.
    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_outs", {rvalid, bvalid, wready, rlast, bresp, rresp}, '0);
        end else begin
            if (rvalid) begin
                if (exp_rq.size() == 0) chk("r_unexpected", rvalid, 0);
                else begin
                    chk("rdata", rdata, exp_rq[0].d);
                    chk("rlast", rlast, exp_rq[0].last);
                    chk("rresp", rresp, 0);
                    if (rready) void'(exp_rq.pop_front());
                end
            end
            if (bvalid) begin
                if (exp_bq.size() == 0) chk("b_unexpected", bvalid, 0);
                else begin
                    chk("bresp", bresp, exp_bq[0]);
                    if (bready) void'(exp_bq.pop_front());
                end
            end
        end
    end

    task automatic hs_wait(input int sel);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            case (sel)
                0:       got = awready;
                1:       got = wready;
                2:       got = arready;
                default: got = bvalid;
            endcase
            @(posedge clk); #1;
        end
        chk($sformatf("hs_wait%0d", sel), got, 1);
    endtask

    // strb_mode: 0 all, 1 random, 2 low 8 bytes; data_mode: 0 random, 1 zero, 2 ones, 3 fixed
    task automatic write_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                               input int early_last, input logic final_last,
                               input int strb_mode, input int data_mode,
                               input logic [511:0] fixed, output logic [1:0] eb);
        int unsigned i;
        logic [511:0] d;
        logic [63:0]  s;
        eb = (final_last && early_last < 0) ? 2'b00 : 2'b10;
        exp_bq.push_back(eb);
        i = midx(addr);
        awaddr = addr; awlen = 8'(len); awburst = burst; awsize = 3'($urandom); awvalid = 1'b1;
        hs_wait(0);
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clk); #1;
            end
            case (data_mode)
                0:       d = rnd512();
                1:       d = '0;
                2:       d = '1;
                default: d = fixed;
            endcase
            case (strb_mode)
                0:       s = '1;
                1:       s = {$urandom, $urandom};
                default: s = 64'hFF;
            endcase
            for (int k = 0; k < 64; k++) if (s[k]) mm[i][8*k +: 8] = d[8*k +: 8];
            wdata = d; wstrb = s; wlast = (b == len) ? final_last : (b == early_last); wvalid = 1'b1;
            hs_wait(1);
            i = nidx(i, burst);
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        chk("b_latency", bvalid, 1);
        @(posedge clk); #1;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bready = 1'b1;
        hs_wait(3);
        bready = 1'b0;
    endtask

    // rmode: 0 always ready, 1 toggle 1/0, 2 random
    task automatic read_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                              input int rmode, input bit chk_lat);
        int unsigned i;
        int got;
        int t;
        logic tog;
        rbeat_t e;
        i = midx(addr);
        for (int b = 0; b <= len; b++) begin
            e.d = mm[i]; e.last = (b == len);
            exp_rq.push_back(e);
            i = nidx(i, burst);
        end
        araddr = addr; arlen = 8'(len); arburst = burst; arsize = 3'($urandom); arvalid = 1'b1;
        hs_wait(2);
        arvalid = 1'b0;
        if (chk_lat) begin
            @(negedge clk); chk("r_lat_n1", rvalid, 0);
            @(negedge clk); chk("r_lat_n2", rvalid, 1);
        end
        got = 0; t = 0; tog = 1'b1;
        while (got <= len && t < 300) begin
            @(posedge clk); #1;
            rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom);
            tog = ~tog;
            @(negedge clk);
            if (rvalid && rready) got++;
            t++;
        end
        @(posedge clk); #1;
        rready = 1'b0;
        chk("r_beats", got, len + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   eb;
        logic [511:0] d1;
        logic [511:0] d;
        int           len;
        int           early;

        reset = 1'b0;
        awaddr = '0; awlen = '0; awburst = '0; awsize = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arburst = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_awready", awready, 1);
        chk("rst_arready", arready, 1);
        @(posedge clk); #1;

        chk("pin_alias", midx(32'h440), 1);
        chk("pin_idx80", midx(32'h80), 2);

        write_burst(32'h0, 15, 2'b01, -1, 1'b1, 0, 0, '0, eb);

        d1 = {16{32'hA5A5_0001}};
        write_burst(32'h40, 0, 2'b01, -1, 1'b1, 0, 3, d1, eb);
        chk("pin_bresp_ok", eb, 2'b00);
        chk("pin_d1", mm[1], {16{32'hA5A5_0001}});
        read_burst(32'h40, 0, 2'b01, 0, 1);

        write_burst(32'h80, 3, 2'b01, -1, 1'b1, 0, 0, '0, eb);
        read_burst(32'h80, 3, 2'b01, 1, 1);

        write_burst(32'h200, 0, 2'b01, -1, 1'b1, 0, 2, '0, eb);
        write_burst(32'h200, 0, 2'b01, -1, 1'b1, 2, 1, '0, eb);
        chk("pin_strb", mm[8], {{56{8'hFF}}, 64'h0});
        read_burst(32'h200, 0, 2'b01, 0, 1);

        write_burst(32'h300, 1, 2'b01, 0, 1'b1, 0, 0, '0, eb);
        chk("pin_early_last", eb, 2'b10);
        write_burst(32'h340, 0, 2'b01, -1, 1'b0, 0, 0, '0, eb);
        chk("pin_no_last", eb, 2'b10);
        read_burst(32'h300, 1, 2'b01, 2, 1);

        write_burst(32'h380, 2, 2'b00, -1, 1'b1, 1, 0, '0, eb);
        read_burst(32'h380, 2, 2'b00, 2, 1);
        write_burst(32'h3C0, 2, 2'b10, -1, 1'b1, 0, 0, '0, eb);
        read_burst(32'h3C0, 2, 2'b10, 0, 1);

        // AR handshake in the same cycle as a W beat; the next W beat blocks the read issue.
        begin
            rbeat_t e;
            e.d = mm[1]; e.last = 1'b1;
            exp_rq.push_back(e);
            exp_bq.push_back(2'b00);
            awaddr = 32'h100; awlen = 8'd1; awburst = 2'b01; awvalid = 1'b1;
            hs_wait(0);
            awvalid = 1'b0;
            d = rnd512(); mm[4] = d;
            wdata = d; wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
            araddr = 32'h440; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
            @(negedge clk);
            chk("conc_arready", arready, 1);
            chk("conc_wready", wready, 1);
            @(posedge clk); #1;
            arvalid = 1'b0;
            d = rnd512(); mm[5] = d;
            wdata = d; wlast = 1'b1;
            @(negedge clk); chk("conc_rv_n1", rvalid, 0);
            @(posedge clk); #1;
            wvalid = 1'b0; wlast = 1'b0;
            @(negedge clk);
            chk("conc_rv_n2", rvalid, 0);
            chk("conc_bvalid", bvalid, 1);
            @(posedge clk); #1;
            @(negedge clk); chk("conc_rv_n3", rvalid, 1);
            @(posedge clk); #1;
            rready = 1'b1; bready = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            rready = 1'b0; bready = 1'b0;
            read_burst(32'h100, 1, 2'b01, 0, 1);
        end

        // Reset while a read beat is being presented.
        begin
            rbeat_t e;
            int unsigned i;
            bit seen;
            i = midx(32'h80);
            for (int b = 0; b <= 2; b++) begin
                e.d = mm[i]; e.last = (b == 2);
                exp_rq.push_back(e);
                i = nidx(i, 2'b01);
            end
            araddr = 32'h80; arlen = 8'd2; arburst = 2'b01; arvalid = 1'b1;
            hs_wait(2);
            arvalid = 1'b0;
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                seen = rvalid;
            end
            chk("rst_rvalid_seen", seen, 1);
            #1 reset = 1'b0;
            #1 chk("rst_rvalid_drop", rvalid, 0);
            exp_rq.delete();
            repeat (2) @(negedge clk);
            #2 reset = 1'b1;
            @(negedge clk);
            chk("rel_arready", arready, 1);
            @(posedge clk); #1;
            read_burst(32'h80, 2, 2'b01, 2, 1);
        end

        for (int n = 0; n < 60; n++) begin
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 0) begin
                early = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
                write_burst($urandom, len, 2'($urandom_range(0, 2)), early,
                            1'($urandom_range(0, 7) != 0), $urandom_range(0, 2), 0, '0, eb);
            end else begin
                read_burst($urandom, len, 2'($urandom_range(0, 2)), $urandom_range(0, 2), 1);
            end
        end

        repeat (3) @(posedge clk);
        chk("rq_drained", exp_rq.size(), 0);
        chk("bq_drained", exp_bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trans_mem_responder.md
TRANS_MEM_RESPONDER -- requirements
Module: trans_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, giving 2^DEPTH_LOG2 table entries of 512 bits each.
REQ-002 SHALL have parameter BASE_ADDRESS, default 32'h00000000, giving the AXI4 byte address of entry 0.
REQ-003 SHALL have clk  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have trans_axi_awaddr/awlen/awburst/awsize/awvalid  input  32/8/2/3/1  write address channel; awready  output  1.
REQ-006 SHALL have trans_axi_wdata/wstrb/wlast/wvalid  input  512/64/1/1  write data channel; wready  output  1.
REQ-007 SHALL have trans_axi_bresp/bvalid  output  2/1  write response; bready  input  1.
REQ-008 SHALL have trans_axi_araddr/arlen/arburst/arsize/arvalid  input  32/8/2/3/1  read address channel; arready  output  1.
REQ-009 SHALL have trans_axi_rdata/rresp/rlast/rvalid  output  512/2/1/1  read data channel; rready  input  1.
REQ-010 SHALL ignore awlock, awcache, awprot, awqos and the ar equivalents; these are not ports.

Function
REQ-011 SHALL store entries in one single-port 512-bit RAM; index = (addr - BASE_ADDRESS) bits [DEPTH_LOG2+5:6]; low 6 bits and upper bits ignored, so out-of-range addresses alias.
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP.
REQ-013 W_IDLE: awready=1, wready=0; on awvalid&&awready capture index, awlen, awburst, clear beat count, go W_DATA.
REQ-014 W_DATA: wready=1, awready=0; each wvalid&&wready beat writes RAM byte lanes where wstrb[k]=1, others unchanged.
REQ-015 Burst FIXED (00): index constant; INCR (01) and WRAP (10, treated as INCR): index+1 per beat, wrapping modulo 2^DEPTH_LOG2.
REQ-016 Write beat with beat count == awlen SHALL end the burst -> W_RESP next cycle; bresp=OKAY (00) if wlast=1 on that beat and never earlier, else SLVERR (10).
REQ-017 A wlast=1 beat before beat count == awlen SHALL be written normally, marked SLVERR, burst continues to awlen.
REQ-018 W_RESP: bvalid=1; on bready go W_IDLE, bvalid=0 next cycle.
REQ-019 Read FSM SHALL have states R_IDLE, R_READ, R_DATA.
REQ-020 R_IDLE: arready=1; on arvalid&&arready capture index, arlen, arburst, go R_READ.
REQ-021 R_READ: issue RAM read unless a write beat is accepted this cycle (write has priority); on issue go R_DATA.
REQ-022 R_DATA: rvalid=1, rdata=RAM output held stable, rresp=OKAY, rlast=1 iff beat count == arlen; on rready: last -> R_IDLE, else advance index per REQ-015 and go R_READ.
REQ-023 Minimum read latency: AR handshake cycle N, rvalid asserted cycle N+2; write response: last W beat cycle N, bvalid cycle N+1.
REQ-024 Read issued after a write beat to the same index SHALL return the written data; no bypass needed since RAM write precedes the read cycle.
REQ-025 arsize/awsize other than 3'b110 SHALL be accepted and treated as 3'b110.
REQ-026 Read and write FSMs SHALL run concurrently; only RAM port access is arbitrated.

Reset
REQ-027 While reset=0: both FSMs in IDLE, awready=arready=1 after release, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=00, beat counters 0.
REQ-028 Reset mid-burst SHALL abandon the transaction with no response; RAM contents are not cleared and bytes already written remain.
REQ-029 RAM contents are undefined after power-up.

Verification
REQ-030 AW addr 0x40, awlen 0, W data D1 wstrb all ones wlast 1 -> bvalid one cycle after W beat, bresp 00; AR 0x40 -> rvalid at N+2, rdata D1, rlast 1.
REQ-031 INCR write awlen 3 at 0x80, then INCR read arlen 3 at 0x80 with rready toggling 1/0 -> four beats D0..D3 in order, rlast only on fourth, rdata stable while rready=0.
REQ-032 Write wstrb 64'h00000000_000000FF over existing all-ones entry with data zero -> readback low 8 bytes 0, rest 0xFF.
REQ-033 awlen 1 with wlast=1 on first beat -> both beats written, bresp 10; awlen 0 with wlast=0 -> bresp 10.
REQ-034 AR and W beat presented same cycle -> write accepted, rvalid delayed one cycle; address 2^DEPTH_LOG2*64 + 0x40 reads entry 1.
REQ-035 Assert reset during R_DATA of arlen 2 read -> rvalid 0 immediately, arready 1 after release, next read returns correct data.
